// File: rtl/rst_pkg.sv
// rst_pkg: sequencer state encoding and reset-cause bit positions.
package rst_pkg;
   typedef enum logic [1:0] {HOLD = 2'd0, RELEASE = 2'd1, RUN = 2'd2} state_e;
   localparam int CAUSE_POR = 0;
   localparam int CAUSE_PIN = 1;
   localparam int CAUSE_SW  = 2;
   localparam int CAUSE_WDT = 3;
   localparam logic [3:0] POR_CAUSE = 4'b0001;
endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: reset requests into the sequencer, staged resets and cause flags out.
interface rst_seq_ctrl_if #(parameter int N_DOM = 4);
   logic             sw_rst_req;
   logic             wdt_expire;
   logic             cause_clr;
   logic [N_DOM-1:0] rst_n_dom;
   logic             seq_busy;
   logic [3:0]       rst_cause;
   modport master (output sw_rst_req, wdt_expire, cause_clr, input rst_n_dom, seq_busy, rst_cause);
   modport slave  (input sw_rst_req, wdt_expire, cause_clr, output rst_n_dom, seq_busy, rst_cause);
endinterface

// File: rtl/rst_pin_debounce.sv
// rst_pin_debounce: synchronises the nRST pin and accepts a level only after it is stable.
module rst_pin_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic nRST,
   output logic pin_low
);
   localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   pin_low_q, pin_low_d, differ, done;
   // pin_low high means the pin should read 0, so equality is a disagreement
   assign differ = sync_q[SYNC_STAGES-1] == pin_low_q;
   assign done   = cnt_q == CW'(DEB_CYCLES - 1);
   always_comb begin
      cnt_d     = differ && !done ? cnt_q + 1'b1 : '0;
      pin_low_d = differ && done ? ~pin_low_q : pin_low_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '1;
         cnt_q     <= '0;
         pin_low_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], nRST};
         cnt_q     <= cnt_d;
         pin_low_q <= pin_low_d;
      end
   end
   assign pin_low = pin_low_q;
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: merges reset sources, holds a minimum pulse, then releases
// the domain resets one by one in ascending order while logging the cause.
module rst_seq_ctrl
   import rst_pkg::*;
#(
   parameter int N_DOM       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 16,
   parameter int PULSE_MIN   = 32,
   parameter int STEP_CYCLES = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          nRST,
   rst_seq_ctrl_if.slave bus
);
   localparam int HW = PULSE_MIN > 1 ? $clog2(PULSE_MIN) : 1;
   localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
   localparam int IW = N_DOM > 1 ? $clog2(N_DOM) : 1;
   state_e           state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [SW-1:0]    step_q, step_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [N_DOM-1:0] dom_q, dom_d;
   logic             busy_q, busy_d;
   logic [3:0]       cause_q, cause_d, hits;
   logic             pin_low, trigger;

   rst_pin_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .nRST   (nRST),
      .pin_low(pin_low)
   );

   always_comb begin
      hits            = '0;
      hits[CAUSE_PIN] = pin_low;
      hits[CAUSE_SW]  = bus.sw_rst_req;
      hits[CAUSE_WDT] = bus.wdt_expire;
   end
   assign trigger = |hits;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      step_d  = step_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      busy_d  = busy_q;
      cause_d = bus.cause_clr && state_q == RUN ? hits : cause_q | hits;
      if (trigger) begin
         state_d = HOLD;
         hold_d  = '0;
         step_d  = '0;
         idx_d   = '0;
         dom_d   = '0;
         busy_d  = 1'b1;
      end else if (state_q == HOLD) begin
         hold_d = hold_q == HW'(PULSE_MIN - 1) ? hold_q : hold_q + 1'b1;
         if (hold_q == HW'(PULSE_MIN - 1)) begin
            state_d = RELEASE;
            step_d  = '0;
            idx_d   = '0;
         end
      end else if (state_q == RELEASE) begin
         step_d = step_q + 1'b1;
         if (step_q == SW'(STEP_CYCLES - 1)) begin
            step_d       = '0;
            dom_d[idx_q] = 1'b1;
            idx_d        = idx_q + 1'b1;
            // last domain out: stay on its index and go idle in the same edge
            if (idx_q == IW'(N_DOM - 1)) begin
               idx_d   = idx_q;
               state_d = RUN;
               busy_d  = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HOLD;
         hold_q  <= '0;
         step_q  <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         busy_q  <= 1'b1;
         cause_q <= POR_CAUSE;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         step_q  <= step_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         busy_q  <= busy_d;
         cause_q <= cause_d;
      end
   end

   assign bus.rst_n_dom = dom_q;
   assign bus.seq_busy  = busy_q;
   assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: three sequencers (1, 4 and 8 domains) share one stimulus and
// are checked every cycle against an age-since-last-reset model.
module tb_rst_seq_ctrl;
   localparam int P   = 32;
   localparam int S   = 8;
   localparam int SYN = 2;
   localparam int D   = 16;

   logic clk = 1'b0, rst_n = 1'b1, nrst = 1'b1, sw = 1'b0, wdt = 1'b0, clr = 1'b0;
   int   checks = 0, errors = 0;
   always #5 clk = ~clk;

   rst_seq_ctrl_if #(.N_DOM(1)) b1 ();
   rst_seq_ctrl_if #(.N_DOM(4)) b4 ();
   rst_seq_ctrl_if #(.N_DOM(8)) b8 ();
   assign b1.sw_rst_req = sw;
   assign b4.sw_rst_req = sw;
   assign b8.sw_rst_req = sw;
   assign b1.wdt_expire = wdt;
   assign b4.wdt_expire = wdt;
   assign b8.wdt_expire = wdt;
   assign b1.cause_clr  = clr;
   assign b4.cause_clr  = clr;
   assign b8.cause_clr  = clr;

   rst_seq_ctrl #(.N_DOM(1), .SYNC_STAGES(SYN), .DEB_CYCLES(D), .PULSE_MIN(P), .STEP_CYCLES(S))
      dut1 (.clk(clk), .rst_n(rst_n), .nRST(nrst), .bus(b1));
   rst_seq_ctrl #(.N_DOM(4), .SYNC_STAGES(SYN), .DEB_CYCLES(D), .PULSE_MIN(P), .STEP_CYCLES(S))
      dut4 (.clk(clk), .rst_n(rst_n), .nRST(nrst), .bus(b4));
   rst_seq_ctrl #(.N_DOM(8), .SYNC_STAGES(SYN), .DEB_CYCLES(D), .PULSE_MIN(P), .STEP_CYCLES(S))
      dut8 (.clk(clk), .rst_n(rst_n), .nRST(nrst), .bus(b8));

   function automatic int nd(int i);
      return i == 0 ? 1 : (i == 1 ? 4 : 8);
   endfunction

   // Model: age counts edges since the last reset event; each output is a
   // threshold on age. The pin is a window test over the synchronised history.
   int          age;
   logic        pin_m;
   logic [63:0] nh, dh;
   logic [3:0]  cause_m [3];
   logic [63:0] dh_n;
   logic [D-1:0] win;
   logic        pin_n, trig;
   logic [3:0]  hit;
   assign dh_n  = {dh[62:0], nh[SYN-1]};
   assign win   = dh_n[D-1:0];
   assign pin_n = pin_m ? !(&win) : ~|win;
   assign trig  = pin_m | sw | wdt;
   assign hit   = {wdt, sw, pin_m, 1'b0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age   <= 0;
         pin_m <= 1'b0;
         nh    <= '1;
         dh    <= '1;
         for (int i = 0; i < 3; i++) cause_m[i] <= 4'b0001;
      end else begin
         nh    <= {nh[62:0], nrst};
         dh    <= dh_n;
         pin_m <= pin_n;
         age   <= trig ? 0 : (age < 1000 ? age + 1 : age);
         for (int i = 0; i < 3; i++)
            cause_m[i] <= clr && age >= P + nd(i) * S ? hit : cause_m[i] | hit;
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   logic [7:0] dom_a [3];
   logic       busy_a [3];
   logic [3:0] cause_a [3];
   assign dom_a[0] = {7'b0, b1.rst_n_dom};
   assign dom_a[1] = {4'b0, b4.rst_n_dom};
   assign dom_a[2] = b8.rst_n_dom;
   assign busy_a[0] = b1.seq_busy;
   assign busy_a[1] = b4.seq_busy;
   assign busy_a[2] = b8.seq_busy;
   assign cause_a[0] = b1.rst_cause;
   assign cause_a[1] = b4.rst_cause;
   assign cause_a[2] = b8.rst_cause;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic [7:0] e;
         e = '0;
         for (int k = 0; k < nd(i); k++) e[k] = age >= P + (k + 1) * S;
         chk($sformatf("dom[N=%0d]", nd(i)), 32'(dom_a[i]), 32'(e));
         chk($sformatf("busy[N=%0d]", nd(i)), 32'(busy_a[i]), 32'(age < P + nd(i) * S));
         chk($sformatf("cause[N=%0d]", nd(i)), 32'(cause_a[i]), 32'(cause_m[i]));
         chk($sformatf("mono[N=%0d]", nd(i)), 32'((dom_a[i] + 8'd1) & dom_a[i]), 32'd0);
      end
   end

   task automatic edges(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("por_dom", 32'(b4.rst_n_dom), 32'h0);
      chk("por_busy", 32'(b4.seq_busy), 32'h1);
      chk("por_cause", 32'(b4.rst_cause), 32'h1);
      #2 rst_n = 1'b1;
      edges(39);
      chk("e39_dom4", 32'(b4.rst_n_dom), 32'h0);
      edges(1);
      chk("e40_dom4", 32'(b4.rst_n_dom), 32'h1);
      chk("e40_busy1", 32'(b1.seq_busy), 32'h0);
      edges(24);
      chk("e64_dom4", 32'(b4.rst_n_dom), 32'hF);
      chk("e64_busy4", 32'(b4.seq_busy), 32'h0);
      chk("e64_dom8", 32'(b8.rst_n_dom), 32'h0F);
      edges(32);
      chk("e96_dom8", 32'(b8.rst_n_dom), 32'hFF);
      chk("e96_cause", 32'(b4.rst_cause), 32'h1);
      // software request from RUN
      sw = 1'b1;
      edges(1);
      sw = 1'b0;
      chk("sw_dom4", 32'(b4.rst_n_dom), 32'h0);
      chk("sw_busy4", 32'(b4.seq_busy), 32'h1);
      chk("sw_cause", 32'(b4.rst_cause), 32'h5);
      edges(39);
      chk("sw39_dom4", 32'(b4.rst_n_dom), 32'h0);
      edges(1);
      chk("sw40_dom4", 32'(b4.rst_n_dom), 32'h1);
      edges(60);
      // short pin glitch is filtered
      nrst = 1'b0;
      edges(10);
      nrst = 1'b1;
      edges(30);
      chk("glitch_dom4", 32'(b4.rst_n_dom), 32'hF);
      chk("glitch_cause", 32'(b4.rst_cause), 32'h5);
      nrst = 1'b0;
      edges(50);
      chk("pin_dom4", 32'(b4.rst_n_dom), 32'h0);
      chk("pin_cause", 32'(b4.rst_cause), 32'h7);
      edges(150);
      nrst = 1'b1;
      edges(57);
      chk("pin57_dom4", 32'(b4.rst_n_dom), 32'h0);
      edges(1);
      chk("pin58_dom4", 32'(b4.rst_n_dom), 32'h1);
      edges(60);
      clr = 1'b1;
      edges(1);
      clr = 1'b0;
      chk("clr_run1", 32'(b1.rst_cause), 32'h0);
      chk("clr_run8", 32'(b8.rst_cause), 32'h0);
      // watchdog while partly released
      sw = 1'b1;
      edges(1);
      sw = 1'b0;
      edges(48);
      chk("rel_dom4", 32'(b4.rst_n_dom), 32'h3);
      wdt = 1'b1;
      edges(1);
      wdt = 1'b0;
      chk("wdt_dom4", 32'(b4.rst_n_dom), 32'h0);
      chk("wdt_cause", 32'(b4.rst_cause), 32'hC);
      edges(5);
      clr = 1'b1;
      edges(1);
      clr = 1'b0;
      chk("clr_hold", 32'(b4.rst_cause), 32'hC);
      edges(33);
      chk("wdt39_dom4", 32'(b4.rst_n_dom), 32'h0);
      edges(1);
      chk("wdt40_dom4", 32'(b4.rst_n_dom), 32'h1);
      edges(60);
      clr = 1'b1;
      sw  = 1'b1;
      edges(1);
      clr = 1'b0;
      sw  = 1'b0;
      chk("clrsw_cause4", 32'(b4.rst_cause), 32'h4);
      chk("clrsw_cause1", 32'(b1.rst_cause), 32'h4);
      // asynchronous reset with no clock edge
      edges(48);
      chk("pre_async_dom4", 32'(b4.rst_n_dom), 32'h3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_dom4", 32'(b4.rst_n_dom), 32'h0);
      chk("async_dom8", 32'(b8.rst_n_dom), 32'h0);
      chk("async_cause", 32'(b4.rst_cause), 32'h1);
      edges(2);
      #2 rst_n = 1'b1;
      edges(100);
      chk("final_dom8", 32'(b8.rst_n_dom), 32'hFF);
      chk("final_dom1", 32'(b1.rst_n_dom), 32'h1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
